// File: rtl/axis_uart_tx.sv
// rtl/axis_uart_tx.sv - stream-to-UART serial transmitter
// Frames are start bit, WIDTH data bits LSB first, then STOP_BITS stop bits, each CLOCK_DIV cycles long.
module axis_uart_tx #(
  parameter int WIDTH     = 8,
  parameter int CLOCK_DIV = 104,
  parameter int STOP_BITS = 1
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [WIDTH-1:0] idata,
  input  logic             ivalid,
  output logic             iready,
  output logic             txd,
  output logic             busy
);

  localparam int MAX_BITS = (WIDTH > STOP_BITS) ? WIDTH : STOP_BITS;
  localparam int CW       = $clog2(CLOCK_DIV);
  localparam int BW       = $clog2(MAX_BITS + 1);

  localparam logic [CW-1:0] DIV_LAST  = CW'(CLOCK_DIV - 1);
  localparam logic [CW-1:0] DIV_ONE   = CW'(1);
  localparam logic [BW-1:0] DATA_LAST = BW'(WIDTH - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
  localparam logic [BW-1:0] BIT_ONE   = BW'(1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic [1:0]       state;
  logic [CW-1:0]    div_cnt;
  logic [BW-1:0]    bit_cnt;
  logic [WIDTH-1:0] shift;
  logic [WIDTH-1:0] shift_next;
  logic             transfer;
  logic             bit_end;
  logic             last_bit;

  assign transfer   = iready & ivalid;
  assign bit_end    = (div_cnt == '0);
  assign last_bit   = (bit_cnt == '0);
  assign shift_next = shift >> 1;

  // bit_cnt holds the bits still to come in the current state after the one on the line.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      iready  <= 1'b1;
      txd     <= 1'b1;
      busy    <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
      shift   <= '0;
    end else if (transfer) begin
      shift   <= idata;
      state   <= START;
      txd     <= 1'b0;
      div_cnt <= DIV_LAST;
      iready  <= 1'b0;
      busy    <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          iready <= 1'b1;
          txd    <= 1'b1;
          busy   <= 1'b0;
        end
        START: begin
          if (bit_end) begin
            state   <= DATA;
            txd     <= shift[0];
            bit_cnt <= DATA_LAST;
            div_cnt <= DIV_LAST;
          end else begin
            div_cnt <= div_cnt - DIV_ONE;
          end
        end
        DATA: begin
          if (bit_end) begin
            div_cnt <= DIV_LAST;
            if (last_bit) begin
              state   <= STOP;
              txd     <= 1'b1;
              bit_cnt <= STOP_LAST;
            end else begin
              shift   <= shift_next;
              txd     <= shift_next[0];
              bit_cnt <= bit_cnt - BIT_ONE;
            end
          end else begin
            div_cnt <= div_cnt - DIV_ONE;
          end
        end
        STOP: begin
          if (bit_end) begin
            if (last_bit) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              bit_cnt <= bit_cnt - BIT_ONE;
              div_cnt <= DIV_LAST;
            end
          end else begin
            div_cnt <= div_cnt - DIV_ONE;
            // Open the input one cycle early so the next word can follow with no gap.
            if (last_bit && div_cnt == DIV_ONE) begin
              iready <= 1'b1;
            end
          end
        end
        default: begin
          state  <= IDLE;
          iready <= 1'b1;
          txd    <= 1'b1;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axis_uart_tx.sv
// tb/tb_axis_uart_tx.sv - self-checking bench for axis_uart_tx
// Two instances: 8/4/1 (F=40) and 7/3/2 (F=30), each tracked by a frame-position model.
module tb_axis_uart_tx;

  localparam int WA = 8, DA = 4, SA = 1, FA = (1 + WA + SA) * DA;
  localparam int WB = 7, DB = 3, SB = 2, FB = (1 + WB + SB) * DB;

  logic       clock = 1'b0;
  logic       resetn = 1'b1;
  logic [7:0] a_data = '0;
  logic       a_valid = 1'b0;
  logic       a_ready, a_txd, a_busy;
  logic [6:0] b_data = '0;
  logic       b_valid = 1'b0;
  logic       b_ready, b_txd, b_busy;

  int checks = 0;
  int errors = 0;

  axis_uart_tx #(.WIDTH(WA), .CLOCK_DIV(DA), .STOP_BITS(SA)) dut_a (
    .clock(clock), .resetn(resetn), .idata(a_data), .ivalid(a_valid),
    .iready(a_ready), .txd(a_txd), .busy(a_busy)
  );

  axis_uart_tx #(.WIDTH(WB), .CLOCK_DIV(DB), .STOP_BITS(SB)) dut_b (
    .clock(clock), .resetn(resetn), .idata(b_data), .ivalid(b_valid),
    .iready(b_ready), .txd(b_txd), .busy(b_busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Line level at position k of a frame carrying word w.
  function automatic logic line_bit(input bit act, input int k, input logic [7:0] w,
                                    input int width, input int div);
    int b;
    if (!act) return 1'b1;
    b = k / div;
    if (b == 0) return 1'b0;
    if (b <= width) return w[b-1];
    return 1'b1;
  endfunction

  bit         ma_active = 1'b0, mb_active = 1'b0;
  int         ma_k = 0, mb_k = 0;
  logic [7:0] ma_word = '0, mb_word = '0;
  logic       ea_ready, ea_txd, eb_ready, eb_txd;

  assign ea_ready = !ma_active || (ma_k == FA - 1);
  assign eb_ready = !mb_active || (mb_k == FB - 1);
  assign ea_txd   = line_bit(ma_active, ma_k, ma_word, WA, DA);
  assign eb_txd   = line_bit(mb_active, mb_k, mb_word, WB, DB);

  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      ma_active <= 1'b0;
      ma_k      <= 0;
    end else if (ea_ready && a_valid) begin
      ma_active <= 1'b1;
      ma_k      <= 0;
      ma_word   <= a_data;
    end else if (ma_active) begin
      if (ma_k == FA - 1) ma_active <= 1'b0;
      ma_k <= ma_k + 1;
    end
  end

  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      mb_active <= 1'b0;
      mb_k      <= 0;
    end else if (eb_ready && b_valid) begin
      mb_active <= 1'b1;
      mb_k      <= 0;
      mb_word   <= {1'b0, b_data};
    end else if (mb_active) begin
      if (mb_k == FB - 1) mb_active <= 1'b0;
      mb_k <= mb_k + 1;
    end
  end

  always @(negedge clock) begin
    chk("a_txd", a_txd, ea_txd);
    chk("a_iready", a_ready, ea_ready);
    chk("a_busy", a_busy, ma_active);
    chk("b_txd", b_txd, eb_txd);
    chk("b_iready", b_ready, eb_ready);
    chk("b_busy", b_busy, mb_active);
  end

  logic cap_txd [0:99];
  logic cap_rdy [0:99];
  logic cap_busy[0:99];

  task automatic capture(input bit use_b, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clock);
      cap_txd[k]  = use_b ? b_txd   : a_txd;
      cap_rdy[k]  = use_b ? b_ready : a_ready;
      cap_busy[k] = use_b ? b_busy  : a_busy;
    end
  endtask

  task automatic check_frame(input string tag, input logic [9:0] groups, input int div, input int f);
    for (int k = 0; k < f; k++) begin
      chk($sformatf("%s_txd_c%0d", tag, k), cap_txd[k], groups[k / div]);
      chk($sformatf("%s_iready_c%0d", tag, k), cap_rdy[k], (k == f - 1));
      chk($sformatf("%s_busy_c%0d", tag, k), cap_busy[k], 1'b1);
    end
    for (int k = f; k < f + 5; k++) begin
      chk($sformatf("%s_idle_txd_c%0d", tag, k), cap_txd[k], 1'b1);
      chk($sformatf("%s_idle_busy_c%0d", tag, k), cap_busy[k], 1'b0);
    end
  endtask

  task automatic send_a(input logic [7:0] d);
    @(posedge clock); #1;
    a_data = d;
    a_valid = 1'b1;
    @(posedge clock); #1;
    a_valid = 1'b0;
    a_data = 8'($urandom);
  endtask

  logic [9:0] exp_a5, exp_81, exp_0f, exp_41;

  initial begin
    exp_a5 = 10'b1101001010;
    exp_81 = 10'b1100000010;
    exp_0f = 10'b1000011110;
    exp_41 = 10'b1110000010;

    // Reset with arbitrary inputs, then a long quiet period.
    resetn = 1'b0;
    a_valid = 1'b1; a_data = 8'($urandom);
    b_valid = 1'b1; b_data = 7'($urandom);
    repeat (3) @(posedge clock);
    #1;
    chk("rst_a_txd", a_txd, 1'b1);
    chk("rst_a_iready", a_ready, 1'b1);
    chk("rst_a_busy", a_busy, 1'b0);
    chk("rst_b_txd", b_txd, 1'b1);
    chk("rst_b_iready", b_ready, 1'b1);
    chk("rst_b_busy", b_busy, 1'b0);
    a_valid = 1'b0; b_valid = 1'b0;
    resetn = 1'b1;
    repeat (100) @(posedge clock);
    #1;
    chk("quiet_a_txd", a_txd, 1'b1);
    chk("quiet_a_iready", a_ready, 1'b1);
    chk("quiet_a_busy", a_busy, 1'b0);

    // Single word 0xA5.
    send_a(8'hA5);
    capture(1'b0, FA + 5);
    check_frame("a5", exp_a5, DA, FA);

    // Back-to-back 0x00 then 0xFF with ivalid held high.
    @(posedge clock); #1;
    a_data = 8'h00; a_valid = 1'b1;
    @(posedge clock); #1;
    a_data = 8'hFF;
    for (int k = 0; k < 85; k++) begin
      @(negedge clock);
      cap_txd[k] = a_txd; cap_rdy[k] = a_ready; cap_busy[k] = a_busy;
      if (k == 40) a_valid = 1'b0;
    end
    for (int k = 0; k < 80; k++) begin
      chk($sformatf("b2b_txd_c%0d", k), cap_txd[k], (k >= 36 && k < 40) || k >= 44);
      chk($sformatf("b2b_busy_c%0d", k), cap_busy[k], 1'b1);
      chk($sformatf("b2b_iready_c%0d", k), cap_rdy[k], (k == 39) || (k == 79));
    end
    chk("b2b_busy_c80", cap_busy[80], 1'b0);

    // Input pulsed mid-frame must be ignored.
    @(posedge clock); #1;
    a_data = 8'h81; a_valid = 1'b1;
    @(posedge clock); #1;
    a_valid = 1'b0;
    for (int k = 0; k < FA + 5; k++) begin
      @(negedge clock);
      if (k == 5) begin a_valid = 1'b1; a_data = 8'h3C; end
      if (k == 21) a_valid = 1'b0;
      cap_txd[k] = a_txd; cap_rdy[k] = a_ready; cap_busy[k] = a_busy;
    end
    check_frame("ign81", exp_81, DA, FA);

    // Reset in cycle 15 of a 0x55 frame, then a clean 0x0F frame.
    @(posedge clock); #1;
    a_data = 8'h55; a_valid = 1'b1;
    @(posedge clock); #1;
    a_valid = 1'b0;
    repeat (15) @(posedge clock);
    #1;
    chk("mid_pre_busy", a_busy, 1'b1);
    resetn = 1'b0;
    #1;
    chk("mid_rst_txd", a_txd, 1'b1);
    chk("mid_rst_iready", a_ready, 1'b1);
    chk("mid_rst_busy", a_busy, 1'b0);
    repeat (2) @(posedge clock);
    #1;
    resetn = 1'b1;
    send_a(8'h0F);
    capture(1'b0, FA + 5);
    check_frame("post0f", exp_0f, DA, FA);

    // Parameter variant: 0x41 on the 7/3/2 instance.
    @(posedge clock); #1;
    b_data = 7'h41; b_valid = 1'b1;
    @(posedge clock); #1;
    b_valid = 1'b0;
    capture(1'b1, FB + 5);
    check_frame("var41", exp_41, DB, FB);

    // Random traffic on both instances, checked by the model every cycle.
    for (int i = 0; i < 4000; i++) begin
      @(posedge clock); #1;
      a_valid = ($urandom_range(0, 2) != 0);
      a_data  = 8'($urandom);
      b_valid = ($urandom_range(0, 3) == 0);
      b_data  = 7'($urandom);
    end
    a_valid = 1'b0; b_valid = 1'b0;
    repeat (100) @(posedge clock);
    #1;
    chk("end_a_busy", a_busy, 1'b0);
    chk("end_b_busy", b_busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_uart_tx.md
# axis_uart_tx

Serial transmitter that consumes words from an axis stream and sends them as asynchronous UART frames on a single output line. It sits directly downstream of an axis fifo or pipe, the serial sink at the end of a stream pipeline. The block uses one clock and a fixed integer clock-cycles-per-bit divider. It supports back-to-back frames with no idle gap when input data is continuously available.

## Interface
- WIDTH, 8, data bits per frame, sent LSB first; WIDTH >= 1
- CLOCK_DIV, 104, clock cycles per serial bit; CLOCK_DIV >= 2
- STOP_BITS, 1, number of stop bits (logic 1) per frame; STOP_BITS >= 1
- clock  input  1  single clock; all state changes on its rising edge
- resetn  input  1  asynchronous, active-low reset
- idata  input  WIDTH  word to transmit
- ivalid  input  1  idata valid
- iready  output  1  registered; block accepts idata on the rising edge where ivalid && iready
- txd  output  1  registered serial line; idle/stop = 1, start = 0
- busy  output  1  registered; high while a frame is being sent

## Operation
- Reset values: iready = 1, txd = 1, busy = 0; state IDLE; divider counter, bit counter and shift register are don't-care.
- The reset is asynchronous, so assertion mid-frame drives txd to 1 immediately and the frame is truncated. No partial-frame recovery is performed.
- States:
  - IDLE
  - START: txd = 0
  - DATA: txd = shift[0]
  - STOP: txd = 1
- IDLE: iready = 1, txd = 1. A transfer latches idata into the shift register, goes to START, drops iready and sets busy.
- Every non-IDLE state lasts CLOCK_DIV cycles per bit, timed by a down-counter of width $clog2(CLOCK_DIV) that reloads to CLOCK_DIV-1 at each bit boundary.
- DATA lasts WIDTH bits. The shift register shifts right by one at each bit boundary.
- STOP lasts STOP_BITS bits.
- The bit counter counts bits remaining in the current state. Its width must hold max(WIDTH, STOP_BITS).
- iready is raised so that it is high during exactly the last clock cycle of the last stop bit.
- At the edge ending that cycle:
  - If ivalid = 1, the transfer occurs: the new word is latched and START begins on the next cycle, with no idle cycle.
  - If ivalid = 0, go to IDLE: busy = 0, iready stays 1.
- ivalid and idata are ignored whenever iready = 0. idata may change freely after its transfer edge.
- busy = 1 from the cycle after a transfer until the cycle after the final stop cycle with no pending transfer.

## Timing
- F = (1 + WIDTH + STOP_BITS) * CLOCK_DIV, the frame length in cycles.
- With the transfer at edge E0, cycle k denotes the cycle after edge E0+k:
  - Start bit: txd = 0 in cycles 0..CLOCK_DIV-1.
  - Data bit i (i = 0..WIDTH-1): cycles (1+i)*CLOCK_DIV .. (2+i)*CLOCK_DIV-1.
  - Stop bits: cycles (1+WIDTH)*CLOCK_DIV .. F-1.
  - iready = 0 in cycles 0..F-2 and iready = 1 in cycle F-1.
- Latency from transfer edge to txd falling edge: 1 cycle.
- Sustained throughput: one word per F cycles.
- An iready-to-transfer combinational path is forbidden; all outputs come directly from flops.

## Test plan
All scenarios use WIDTH=8, CLOCK_DIV=4, STOP_BITS=1 (F=40) unless stated.

- **Reset:** assert resetn=0 with arbitrary inputs -> txd=1, iready=1, busy=0. Release, keep ivalid=0 for 100 cycles -> outputs unchanged.
- **Single word:** send 0xA5 (single transfer, then ivalid=0).
  - txd in 4-cycle groups: 0, 1,0,1,0,0,1,0,1, 1.
  - iready=0 in cycles 0..38, 1 in cycle 39.
  - busy=0 from cycle 40; txd stays 1 afterwards.
- **Back-to-back:** ivalid held high with 0x00 then 0xFF.
  - Second transfer occurs at the edge ending cycle 39; second start bit begins in cycle 40.
  - txd=0 in cycles 0..35, then 1 in cycles 36..39.
  - Second frame: txd=0 in cycles 40..43, then 1 for the remaining 36 cycles; busy never drops between frames.
- **Ignored input:** pulse ivalid with 0x3C during cycles 5..20 of a 0x81 frame -> no transfer; exactly one frame (0x81) is observed, then IDLE.
- **Mid-frame reset:** assert resetn=0 in cycle 15 of a 0x55 frame -> txd=1, iready=1, busy=0 immediately. After release, sending 0x0F produces a complete, correct frame.
- **Parameter variant:** WIDTH=7, CLOCK_DIV=3, STOP_BITS=2 (F=30); send 0x41.
  - Bit sequence: 0, 1,0,0,0,0,0,1, 1,1, each bit lasting 3 cycles.
  - iready high only in cycle 29.
